// File: rtl/median_pkg.sv
// Shared constants and unsigned min/max/median-of-3 helpers for the 3x3 median stage.
// Helpers work on a wide pixel type; callers size-cast in and out.
package median_pkg;
    localparam int LATENCY    = 3;
    localparam int DATA_W_DEF = 2;
    localparam int PIX_W_MAX  = 16;
    localparam logic [1:0] FILL_FULL = 2'd3;

    typedef logic [PIX_W_MAX-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction
endpackage

// File: rtl/sort3.sv
// Combinational three-input compare-swap network: orders one column into lo/md/hi.
module sort3 #(
    parameter int DATA_W = 2
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_md,
    output logic [DATA_W-1:0] o_hi
);
    logic [DATA_W-1:0] w_p;
    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] w_r;

    assign w_p  = (i_a < i_b) ? i_a : i_b;
    assign w_q  = (i_a < i_b) ? i_b : i_a;
    assign w_r  = (w_q < i_c) ? w_q : i_c;
    assign o_hi = (w_q < i_c) ? i_c : w_q;
    assign o_lo = (w_p < w_r) ? w_p : w_r;
    assign o_md = (w_p < w_r) ? w_r : w_p;
endmodule

// File: rtl/median3x3_stage.sv
// 3x3 sliding-window median (Smith network), one pixel per valid column, latency 3 cycles.
// No backpressure: pipeline advances every cycle, bubbles surface as dout_valid=0.
module median3x3_stage
    import median_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              line_start,
    input  logic [DATA_W-1:0] col_top,
    input  logic [DATA_W-1:0] col_mid,
    input  logic [DATA_W-1:0] col_bot,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              hsync_out,
    output logic              vsync_out
);
    logic [DATA_W-1:0]  w_lo;
    logic [DATA_W-1:0]  w_md;
    logic [DATA_W-1:0]  w_hi;
    logic               w_win_ok;

    logic [DATA_W-1:0]  r_lo [0:2];
    logic [DATA_W-1:0]  r_md [0:2];
    logic [DATA_W-1:0]  r_hi [0:2];
    logic [DATA_W-1:0]  r_l;
    logic [DATA_W-1:0]  r_m;
    logic [DATA_W-1:0]  r_h;
    logic [DATA_W-1:0]  r_dout;
    logic [1:0]         r_fill;
    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_hs;
    logic [LATENCY-1:0] r_vs;

    sort3 #(.DATA_W(DATA_W)) u_sort3 (
        .i_a  (col_top),
        .i_b  (col_mid),
        .i_c  (col_bot),
        .o_lo (w_lo),
        .o_md (w_md),
        .o_hi (w_hi)
    );

    // Window is complete once two earlier columns of this line are already held.
    assign w_win_ok = pix_valid & (r_fill >= 2'd2) & ~line_start & ~vsync_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_lo[i] <= '0;
                r_md[i] <= '0;
                r_hi[i] <= '0;
            end
            r_l    <= '0;
            r_m    <= '0;
            r_h    <= '0;
            r_dout <= '0;
            r_fill <= 2'd0;
            r_vld  <= '0;
            r_hs   <= '0;
            r_vs   <= '0;
        end else begin
            if (pix_valid) begin
                r_lo[2] <= r_lo[1];
                r_lo[1] <= r_lo[0];
                r_lo[0] <= w_lo;
                r_md[2] <= r_md[1];
                r_md[1] <= r_md[0];
                r_md[0] <= w_md;
                r_hi[2] <= r_hi[1];
                r_hi[1] <= r_hi[0];
                r_hi[0] <= w_hi;
            end

            r_l <= DATA_W'(max3(pix_t'(r_lo[0]), pix_t'(r_lo[1]), pix_t'(r_lo[2])));
            r_m <= DATA_W'(med3(pix_t'(r_md[0]), pix_t'(r_md[1]), pix_t'(r_md[2])));
            r_h <= DATA_W'(min3(pix_t'(r_hi[0]), pix_t'(r_hi[1]), pix_t'(r_hi[2])));
            r_dout <= DATA_W'(med3(pix_t'(r_l), pix_t'(r_m), pix_t'(r_h)));

            // vsync wins over line_start so a frame boundary always empties the window.
            if (vsync_in)
                r_fill <= 2'd0;
            else if (line_start)
                r_fill <= pix_valid ? 2'd1 : 2'd0;
            else if (pix_valid && r_fill != FILL_FULL)
                r_fill <= r_fill + 2'd1;

            r_vld <= {r_vld[LATENCY-2:0], w_win_ok};
            r_hs  <= {r_hs[LATENCY-2:0], hsync_in};
            r_vs  <= {r_vs[LATENCY-2:0], vsync_in};
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_vld[LATENCY-1];
    assign hsync_out  = r_hs[LATENCY-1];
    assign vsync_out  = r_vs[LATENCY-1];
endmodule

// File: tb/tb_median3x3_stage.sv
// Bench for median3x3_stage: a 9-pixel sort-based reference with a 3-cycle expectation
// queue checked every cycle, plus literal expectations for the directed cases.
module tb_median3x3_stage;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pix_valid = 1'b0;
    logic         line_start = 1'b0;
    logic [W-1:0] col_top = '0;
    logic [W-1:0] col_mid = '0;
    logic [W-1:0] col_bot = '0;
    logic         hsync_in = 1'b0;
    logic         vsync_in = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         hsync_out;
    logic         vsync_out;

    median3x3_stage #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .line_start (line_start),
        .col_top    (col_top),
        .col_mid    (col_mid),
        .col_bot    (col_bot),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int d;
        bit hs;
        bit vs;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   last_out = 0;
    exp_t pipe [$];
    int   colq [$];
    int   cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and per-cycle comparison.
    initial begin
        exp_t e;
        exp_t z;
        int   tmp [$];
        z = '{v: 1'b0, d: 0, hs: 1'b0, vs: 1'b0};
        forever begin
            @(posedge clk);
            if (!rst) begin
                e.v  = pix_valid && (cnt >= 2) && !line_start && !vsync_in;
                e.hs = hsync_in;
                e.vs = vsync_in;
                e.d  = 0;
                if (pix_valid) begin
                    colq.push_back(int'(col_top));
                    colq.push_back(int'(col_mid));
                    colq.push_back(int'(col_bot));
                    while (colq.size() > 9) void'(colq.pop_front());
                end
                if (e.v && colq.size() == 9) begin
                    tmp = colq;
                    tmp.sort();
                    e.d = tmp[4];
                end
                pipe.push_back(e);
                if (vsync_in)        cnt = 0;
                else if (line_start) cnt = pix_valid ? 1 : 0;
                else if (pix_valid)  cnt++;
            end
            @(negedge clk);
            if (rst) begin
                chk("rst_dout", int'(dout), 0);
                chk("rst_dout_valid", int'(dout_valid), 0);
                chk("rst_hsync_out", int'(hsync_out), 0);
                chk("rst_vsync_out", int'(vsync_out), 0);
                pipe.delete();
                repeat (3) pipe.push_back(z);
                colq.delete();
                cnt = 0;
            end else if (pipe.size() > 0) begin
                e = pipe.pop_front();
                chk("dout_valid", int'(dout_valid), int'(e.v));
                chk("hsync_out", int'(hsync_out), int'(e.hs));
                chk("vsync_out", int'(vsync_out), int'(e.vs));
                if (e.v) chk("dout", int'(dout), e.d);
                if (dout_valid) begin
                    n_out++;
                    last_out = int'(dout);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic ls, input logic [W-1:0] t,
                       input logic [W-1:0] m, input logic [W-1:0] b,
                       input logic hs, input logic vs);
        pix_valid  = v;
        line_start = ls;
        col_top    = t;
        col_mid    = m;
        col_bot    = b;
        hsync_in   = hs;
        vsync_in   = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [W-1:0] rp();
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    initial begin
        int n0;

        // Reset held with random inputs; the compare process checks zeros.
        repeat (8) cyc(1'($urandom), 1'($urandom), rp(), rp(), rp(), 1'($urandom), 1'($urandom));
        rst = 1'b0;
        idle(2);

        // Three-column line: window {2,3,0,3,0,1,0,3,0} has median 1.
        n0 = n_out;
        cyc(1, 1, 2'd2, 2'd3, 2'd0, 0, 0);
        cyc(1, 0, 2'd3, 2'd0, 2'd1, 0, 0);
        cyc(1, 0, 2'd0, 2'd3, 2'd0, 0, 0);
        idle(1);
        chk("t2_not_yet", int'(dout_valid), 0);
        idle(1);
        chk("t2_valid", int'(dout_valid), 1);
        chk("t2_dout", int'(dout), 1);
        idle(1);
        chk("t2_single_pulse", int'(dout_valid), 0);
        idle(3);
        chk("t2_count", n_out - n0, 1);

        // Impulse in a flat line is removed.
        n0 = n_out;
        for (int i = 0; i < 5; i++)
            cyc(1, i == 0, 2'd3, (i == 2) ? 2'd0 : 2'd3, 2'd3, 0, 0);
        idle(5);
        chk("t3_count", n_out - n0, 3);
        chk("t3_last", last_out, 3);

        // Alternating pix_valid.
        n0 = n_out;
        cyc(1, 1, rp(), rp(), rp(), 0, 0);
        for (int i = 0; i < 11; i++)
            cyc(i % 2 == 1, 0, rp(), rp(), rp(), 0, 0);
        idle(5);
        chk("t4_count", n_out - n0, 4);

        // line_start and vsync mid-stream.
        n0 = n_out;
        for (int i = 0; i < 4; i++) cyc(1, i == 0, rp(), rp(), rp(), 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, i == 0, rp(), rp(), rp(), 0, 0);
        cyc(1, 0, rp(), rp(), rp(), 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, rp(), rp(), rp(), 0, 0);
        idle(5);
        chk("t5_count", n_out - n0, 6);

        // Sync pulses reappear exactly 3 cycles later.
        cyc(0, 0, '0, '0, '0, 1, 0);
        idle(1);
        chk("t6_hs_early", int'(hsync_out), 0);
        idle(1);
        chk("t6_hs_on", int'(hsync_out), 1);
        idle(1);
        chk("t6_hs_off", int'(hsync_out), 0);
        cyc(0, 0, '0, '0, '0, 0, 1);
        idle(1);
        chk("t6_vs_early", int'(vsync_out), 0);
        idle(1);
        chk("t6_vs_on", int'(vsync_out), 1);
        idle(1);
        chk("t6_vs_off", int'(vsync_out), 0);

        // Async reset mid-line forces outputs low without a clock edge.
        for (int i = 0; i < 6; i++) cyc(1, i == 0, 2'd3, 2'd3, 2'd3, 1, 0);
        chk("t6_pre_valid", int'(dout_valid), 1);
        chk("t6_pre_dout", int'(dout), 3);
        rst = 1'b1;
        #1;
        chk("t6_async_dout", int'(dout), 0);
        chk("t6_async_valid", int'(dout_valid), 0);
        chk("t6_async_hs", int'(hsync_out), 0);
        idle(2);
        rst = 1'b0;
        n0 = n_out;
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'd2, 2'd2, 2'd2, 0, 0);
        idle(5);
        chk("t6_after_rst_count", n_out - n0, 1);
        chk("t6_after_rst_dout", last_out, 2);

        // Randomized traffic with occasional line/frame boundaries and resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rp(), rp(), rp(),
                $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
